// File: rtl/us_ranger_pkg.sv
// us_ranger_pkg: shared types and constants for the multi-channel ultrasonic ranger.
package us_ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam int SCALE_NUM   = 225;
    localparam int SCALE_SHIFT = 16;
    localparam int CNT_W       = 21;
    localparam int MM_W        = CNT_W + 8 - SCALE_SHIFT;

    // Echo width in clk cycles -> millimetres: (w * 225) >> 16, 21b x 8b product, truncated.
    function automatic logic [MM_W-1:0] width_to_mm(input logic [CNT_W-1:0] w);
        logic [CNT_W+7:0] p;
        p = {8'd0, w} * (CNT_W+8)'(SCALE_NUM);
        return p[CNT_W+7:SCALE_SHIFT];
    endfunction

endpackage

// File: rtl/us_ranger_multi_sync.sv
// us_echo_sync: 2-FF synchroniser for one raw echo input plus rise/fall pulses
// derived from the synchronised level.
module us_echo_sync (
    input  logic clk_50M,
    input  logic reset,
    input  logic echo_rx,
    output logic rise,
    output logic fall
);
    logic s1, s2, prev;

    // Synchronise the async echo and keep one cycle of history for edge detection
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= echo_rx;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/us_ranger_multi.sv
// us_ranger_multi: round-robin HC-SR04 controller. Fires one masked channel at a time,
// times its echo, converts to mm and posts a per-channel result with a valid strobe.
// Optional build macro US_AVG_FILTER_EN: per-channel 4-deep moving average of good
// results (adds one cycle to the result path).
module us_ranger_multi
    import us_ranger_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TRIG_CYC    = 500,
    parameter int PERIOD_CYC  = 3_000_000,
    parameter int TIMEOUT_CYC = 1_500_000,
    parameter int DIST_W      = 16,
    parameter int THRESH_MM   = 300,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic [N_CH-1:0]        echo_rx,
    output logic [N_CH-1:0]        trig,
    output logic [N_CH*DIST_W-1:0] dist_mm,
    output logic                   dist_valid,
    output logic [CH_W-1:0]        dist_ch,
    output logic [N_CH-1:0]        obj,
    output logic [N_CH-1:0]        timeout
);
    localparam int PER_W = $clog2(PERIOD_CYC);
    localparam logic [63:0] DMAX = (64'd1 << DIST_W) - 64'd1;
    localparam logic [DIST_W-1:0] THRESH_V = DIST_W'(THRESH_MM);

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, width;
    logic [PER_W-1:0] per_cnt;
    logic [CH_W-1:0]  ch, ch_nxt;
    logic             first, found, go;
    logic             ev, ev_to, ev_sat;
    int               idx;
    logic [N_CH-1:0]  rise, fall;

    logic             ev_q, ev_to_q, ev_sat_q;
    logic [CH_W-1:0]  ev_ch_q;
    logic [CNT_W-1:0] ev_w_q;
    logic [MM_W-1:0]  mm_raw;
    logic [DIST_W-1:0] conv;

    logic             r_vld, r_to, r_sat;
    logic [CH_W-1:0]  r_ch;
    logic [DIST_W-1:0] r_mm;
    logic [N_CH-1:0][DIST_W-1:0] dist_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_sync
        us_echo_sync u_sync (
            .clk_50M (clk_50M),
            .reset   (reset),
            .echo_rx (echo_rx[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // Next masked channel after the current one (from ch0 on the first pick after reset)
    always_comb begin
        ch_nxt = ch;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = first ? k : (int'(ch) + 1 + k) % N_CH;
            if (!found && ch_mask[CH_W'(idx)]) begin
                ch_nxt = CH_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus go/result-event strobes
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        ev        = 1'b0;
        ev_to     = 1'b0;
        ev_sat    = 1'b0;
        case (state)
            IDLE: if (enable && found) begin
                state_nxt = TRIG;
                go        = 1'b1;
            end
            TRIG: if (cnt == CNT_W'(TRIG_CYC - 1)) state_nxt = WAIT_RISE;
            WAIT_RISE: begin
                if (rise[ch]) state_nxt = MEASURE;
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = HOLDOFF;
                    ev        = 1'b1;
                    ev_to     = 1'b1;
                end
            end
            MEASURE: begin
                if (fall[ch]) begin
                    state_nxt = HOLDOFF;
                    ev        = 1'b1;
                end else if (width == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = HOLDOFF;
                    ev        = 1'b1;
                    ev_to     = 1'b1;
                    ev_sat    = 1'b1;
                end
            end
            HOLDOFF: if (per_cnt == PER_W'(PERIOD_CYC - 1)) begin
                if (enable && found) begin
                    state_nxt = TRIG;
                    go        = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Phase counter, echo width, trigger-to-trigger period (saturating) and channel pointer
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            width   <= '0;
            per_cnt <= '0;
            ch      <= '0;
            first   <= 1'b1;
        end else begin
            cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            if (state == WAIT_RISE)    width <= CNT_W'(1);
            else if (state == MEASURE) width <= width + CNT_W'(1);
            if (go) begin
                per_cnt <= '0;
                ch      <= ch_nxt;
                first   <= 1'b0;
            end else if (per_cnt != PER_W'(PERIOD_CYC - 1)) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

    // Trigger is decoded from registered state so it drops as soon as reset asserts
    always_comb begin
        trig = '0;
        if (state == TRIG) trig[ch] = 1'b1;
    end

    // Capture the finished measurement for the conversion stage
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            ev_q     <= 1'b0;
            ev_to_q  <= 1'b0;
            ev_sat_q <= 1'b0;
            ev_ch_q  <= '0;
            ev_w_q   <= '0;
        end else begin
            ev_q <= ev;
            if (ev) begin
                ev_to_q  <= ev_to;
                ev_sat_q <= ev_sat;
                ev_ch_q  <= ch;
                ev_w_q   <= width;
            end
        end
    end

    assign mm_raw = width_to_mm(ev_w_q);
    assign conv   = (64'(mm_raw) > DMAX) ? '1 : DIST_W'(mm_raw);

`ifdef US_AVG_FILTER_EN
    logic [DIST_W-1:0] hist [N_CH][4];
    logic [N_CH-1:0]   seeded;
    logic              b_q, b_to, b_sat;
    logic [CH_W-1:0]   b_ch;
    logic [DIST_W+1:0] sum;

    // History update on good results; the first good sample fills all four slots
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++)
                for (int j = 0; j < 4; j++) hist[i][j] <= '0;
            seeded <= '0;
            b_q    <= 1'b0;
            b_to   <= 1'b0;
            b_sat  <= 1'b0;
            b_ch   <= '0;
        end else begin
            b_q <= ev_q;
            if (ev_q) begin
                b_to  <= ev_to_q;
                b_sat <= ev_sat_q;
                b_ch  <= ev_ch_q;
                if (!ev_to_q) begin
                    if (!seeded[ev_ch_q]) begin
                        for (int j = 0; j < 4; j++) hist[ev_ch_q][j] <= conv;
                        seeded[ev_ch_q] <= 1'b1;
                    end else begin
                        hist[ev_ch_q][3] <= hist[ev_ch_q][2];
                        hist[ev_ch_q][2] <= hist[ev_ch_q][1];
                        hist[ev_ch_q][1] <= hist[ev_ch_q][0];
                        hist[ev_ch_q][0] <= conv;
                    end
                end
            end
        end
    end

    assign sum   = {2'b00, hist[b_ch][0]} + {2'b00, hist[b_ch][1]}
                 + {2'b00, hist[b_ch][2]} + {2'b00, hist[b_ch][3]};
    assign r_vld = b_q;
    assign r_ch  = b_ch;
    assign r_to  = b_to;
    assign r_sat = b_sat;
    assign r_mm  = sum[DIST_W+1:2];
`else
    assign r_vld = ev_q;
    assign r_ch  = ev_ch_q;
    assign r_to  = ev_to_q;
    assign r_sat = ev_sat_q;
    assign r_mm  = conv;
`endif

    // Per-channel result registers; a no-rise timeout leaves the old distance in place
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            dist_r     <= '0;
            obj        <= '0;
            timeout    <= '0;
            dist_ch    <= '0;
            dist_valid <= 1'b0;
        end else begin
            dist_valid <= r_vld;
            if (r_vld) begin
                dist_ch       <= r_ch;
                timeout[r_ch] <= r_to;
                if (!r_to) begin
                    dist_r[r_ch] <= r_mm;
                    obj[r_ch]    <= (r_mm < THRESH_V);
                end else begin
                    obj[r_ch] <= 1'b0;
                    if (r_sat) dist_r[r_ch] <= '1;
                end
            end
        end
    end

    assign dist_mm = dist_r;

endmodule

// File: tb/tb_us_ranger_multi.sv
// tb_us_ranger_multi: directed bench with shortened timing parameters.
// Widths 1457 -> 5 mm, 4370 -> 15 mm; THRESH 10 mm.
`timescale 1ns/1ps
module tb_us_ranger_multi;
    localparam int N_CH        = 4;
    localparam int TRIG_CYC    = 10;
    localparam int PERIOD_CYC  = 6000;
    localparam int TIMEOUT_CYC = 5000;
    localparam int DIST_W      = 16;
    localparam int THRESH_MM   = 10;
`ifdef US_AVG_FILTER_EN
    localparam int XLAT = 1, EXP_T2 = 7, EXP_T3B = 7;
`else
    localparam int XLAT = 0, EXP_T2 = 15, EXP_T3B = 5;
`endif

    logic                   clk_50M = 1'b0;
    logic                   reset = 1'b0;
    logic                   enable = 1'b0;
    logic [N_CH-1:0]        ch_mask = '0;
    logic [N_CH-1:0]        echo_rx = '0;
    logic [N_CH-1:0]        trig;
    logic [N_CH*DIST_W-1:0] dist_mm;
    logic                   dist_valid;
    logic [1:0]             dist_ch;
    logic [N_CH-1:0]        obj;
    logic [N_CH-1:0]        timeout;

    int cyc = 0, checks = 0, errors = 0, n_valid = 0, n_bad02 = 0;
    logic watch02 = 1'b0;

    us_ranger_multi #(
        .N_CH(N_CH), .TRIG_CYC(TRIG_CYC), .PERIOD_CYC(PERIOD_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .DIST_W(DIST_W), .THRESH_MM(THRESH_MM)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .echo_rx(echo_rx), .trig(trig), .dist_mm(dist_mm), .dist_valid(dist_valid),
        .dist_ch(dist_ch), .obj(obj), .timeout(timeout)
    );

    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;
    always @(negedge clk_50M) begin
        if (dist_valid) n_valid <= n_valid + 1;
        if (watch02 && (trig[0] || trig[2])) n_bad02 <= n_bad02 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    // Wait for the next trigger rise; sampled on the first negedge with trig high
    task automatic wait_trig(output logic [N_CH-1:0] tv, output int st);
        int k = 0;
        while (trig != '0 && k < 3*PERIOD_CYC) begin @(negedge clk_50M); k++; end
        while (trig == '0 && k < 3*PERIOD_CYC) begin @(negedge clk_50M); k++; end
        chk("trig_seen", 64'(trig != '0), 64'd1);
        tv = trig;
        st = cyc;
    endtask

    task automatic trig_len(output int n);
        n = 0;
        while (trig != '0 && n < 1000) begin n++; @(negedge clk_50M); end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!dist_valid && k < 8000) begin @(negedge clk_50M); k++; end
        chk("valid_seen", 64'(dist_valid), 64'd1);
    endtask

    task automatic pulse(input int c, input int w);
        @(posedge clk_50M); #1 echo_rx[c] = 1'b1;
        repeat (w) @(posedge clk_50M);
        #1 echo_rx[c] = 1'b0;
    endtask

    initial begin
        logic [N_CH-1:0] tv;
        int t0, t1, n, v0;

        #35;
        chk("rst_trig", 64'(trig), 0);
        chk("rst_dist", 64'(dist_mm), 0);
        chk("rst_valid", 64'(dist_valid), 0);
        chk("rst_obj", 64'(obj), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_ch", 64'(dist_ch), 0);
        @(negedge clk_50M);
        reset = 1'b1; ch_mask = 4'b0001; enable = 1'b1;

        // 1: single channel, 5 mm, near
        wait_trig(tv, t0);
        chk("t1_trig", 64'(tv), 64'b0001);
        trig_len(n);
        chk("t1_trig_len", 64'(n), 64'(TRIG_CYC));
        v0 = n_valid;
        tick(5); pulse(0, 1457); wait_valid();
        chk("t1_dist", 64'(dist_mm[15:0]), 5);
        chk("t1_obj", 64'(obj[0]), 1);
        chk("t1_ch", 64'(dist_ch), 0);
        tick(5);
        chk("t1_nvalid", 64'(n_valid - v0), 1);

        // 2: 15 mm, not near; period spacing
        wait_trig(tv, t1);
        chk("t2_period", 64'(t1 - t0), 64'(PERIOD_CYC));
        trig_len(n); tick(5); pulse(0, 4370); wait_valid();
        chk("t2_dist", 64'(dist_mm[15:0]), 64'(EXP_T2));
        chk("t2_obj", 64'(obj[0]), 64'(EXP_T2 < THRESH_MM));

        // 3: no echo -> timeout at exact cycle, distance held
        wait_trig(tv, t0);
        while (cyc < t0 + TRIG_CYC + TIMEOUT_CYC + XLAT) @(negedge clk_50M);
        chk("t3_to_early", 64'(timeout[0]), 0);
        @(negedge clk_50M);
        chk("t3_to_set", 64'(timeout[0]), 1);
        chk("t3_to_valid", 64'(dist_valid), 1);
        chk("t3_dist_held", 64'(dist_mm[15:0]), 64'(EXP_T2));
        chk("t3_obj", 64'(obj[0]), 0);

        // 3b: good echo clears timeout
        wait_trig(tv, t0);
        trig_len(n); tick(5); pulse(0, 1457); wait_valid();
        chk("t3b_to_clr", 64'(timeout[0]), 0);
        chk("t3b_dist", 64'(dist_mm[15:0]), 64'(EXP_T3B));

        // 3c: echo stuck high -> saturated distance
        wait_trig(tv, t0);
        trig_len(n); tick(5);
        @(posedge clk_50M); #1 echo_rx[0] = 1'b1;
        wait_valid();
        chk("t3c_to", 64'(timeout[0]), 1);
        chk("t3c_dist", 64'(dist_mm[15:0]), 64'hFFFF);
        chk("t3c_obj", 64'(obj[0]), 0);
        echo_rx[0] = 1'b0;
        ch_mask = 4'b1010;

        // 4: mask 1010 alternates ch1/ch3 at exact period
        watch02 = 1'b1;
        wait_trig(tv, t0);
        chk("t4_first", 64'(tv), 64'b0010);
        wait_trig(tv, t1);
        chk("t4_second", 64'(tv), 64'b1000);
        chk("t4_period_a", 64'(t1 - t0), 64'(PERIOD_CYC));
        wait_trig(tv, t0);
        chk("t4_third", 64'(tv), 64'b0010);
        chk("t4_period_b", 64'(t0 - t1), 64'(PERIOD_CYC));
        watch02 = 1'b0;
        chk("t4_no_ch02", 64'(n_bad02), 0);

        // 5: reset mid-MEASURE clears everything at once
        trig_len(n); tick(5);
        @(posedge clk_50M); #1 echo_rx[1] = 1'b1;
        tick(100);
        #3 reset = 1'b0;
        #1;
        chk("t5_trig", 64'(trig), 0);
        chk("t5_dist", 64'(dist_mm), 0);
        chk("t5_timeout", 64'(timeout), 0);
        chk("t5_obj", 64'(obj), 0);
        chk("t5_ch", 64'(dist_ch), 0);
        echo_rx[1] = 1'b0;
        tick(3);
        reset = 1'b1;
        wait_trig(tv, t0);
        chk("t5_first_after", 64'(tv), 64'b0010);

        // 6: enable dropped in WAIT_RISE -> result posted, then idle
        trig_len(n);
        enable = 1'b0;
        tick(5);
        v0 = n_valid;
        pulse(1, 1457); wait_valid();
        chk("t6_dist", 64'(dist_mm[31:16]), 5);
        chk("t6_ch", 64'(dist_ch), 1);
        chk("t6_obj", 64'(obj[1]), 1);
        n = 0;
        repeat (2*PERIOD_CYC) begin @(negedge clk_50M); if (trig != '0) n++; end
        chk("t6_idle", 64'(n), 0);
        chk("t6_nvalid", 64'(n_valid - v0), 1);
        ch_mask = 4'b0000; enable = 1'b1;
        n = 0;
        repeat (300) begin @(negedge clk_50M); if (trig != '0) n++; end
        chk("t6_mask0", 64'(n), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
